// File: rtl/memory_stage.sv
// Memory stage of the pipeline: data memory access, branch decision,
// registered hand-off to write-back and a debug read port.
module memory_stage #(
  parameter int len       = 32,
  parameter int NB        = $clog2(len),
  parameter int ram_depth = 256,
  localparam int AW       = $clog2(ram_depth)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic [len-1:0]  in_pc_branch,
  input  logic [len-1:0]  in_alu,
  input  logic            in_zero_flag,
  input  logic            in_neg_flag,
  input  logic [len-1:0]  in_reg2,
  input  logic [NB-1:0]   in_write_reg,
  input  logic [2:0]      memory_bus,
  input  logic [1:0]      writeBack_bus,
  input  logic [AW-1:0]   debug_addr,
  output logic            out_pc_src,
  output logic [len-1:0]  out_pc_branch,
  output logic [len-1:0]  out_read_data,
  output logic [len-1:0]  out_alu,
  output logic [NB-1:0]   out_write_reg,
  output logic [1:0]      writeBack_bus_out,
  output logic [len-1:0]  out_debug_data,
  output logic            misalign_error
);

  logic [len-1:0] mem [ram_depth];

  logic          branch;
  logic          mem_read;
  logic          mem_write;
  logic          aligned;
  logic          misaligned_access;
  logic [AW-1:0] word_addr;
  logic          unused_neg_flag;

  assign branch    = memory_bus[2];
  assign mem_read  = memory_bus[1];
  assign mem_write = memory_bus[0];

  // Byte address to word index; upper address bits wrap around the memory.
  assign word_addr = in_alu[AW+1:2];
  assign aligned   = (in_alu[1:0] == 2'b00);

  assign misaligned_access = enable && (mem_read || mem_write) && !aligned;

  // The negative flag travels with the stage but no decision here uses it.
  assign unused_neg_flag = in_neg_flag;

  // Branch resolution is purely combinational so fetch can redirect this cycle.
  assign out_pc_src    = branch & in_zero_flag;
  assign out_pc_branch = in_pc_branch;

  // Memory array write: only aligned, enabled, out-of-reset stores land.
  always_ff @(posedge clk) begin
    if (!reset && enable && mem_write && aligned) begin
      mem[word_addr] <= in_reg2;
    end
  end

  // Pipeline registers, load data, debug read and the sticky misalign flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_read_data     <= '0;
      out_alu           <= '0;
      out_write_reg     <= '0;
      writeBack_bus_out <= '0;
      out_debug_data    <= '0;
      misalign_error    <= 1'b0;
    end else begin
      out_debug_data <= mem[debug_addr];
      if (misaligned_access) begin
        misalign_error <= 1'b1;
      end
      if (enable) begin
        out_alu           <= in_alu;
        out_write_reg     <= in_write_reg;
        writeBack_bus_out <= writeBack_bus;
        out_read_data     <= (mem_read && aligned) ? mem[word_addr] : '0;
      end
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: stores, loads, branch, stall, misalign,
// address wrap and reset behaviour with hand-computed expectations.
module tb_memory_stage;

  localparam int LEN   = 32;
  localparam int NBW   = $clog2(LEN);
  localparam int DEPTH = 256;
  localparam int AWW   = $clog2(DEPTH);

  logic            clk;
  logic            reset;
  logic            enable;
  logic [LEN-1:0]  in_pc_branch;
  logic [LEN-1:0]  in_alu;
  logic            in_zero_flag;
  logic            in_neg_flag;
  logic [LEN-1:0]  in_reg2;
  logic [NBW-1:0]  in_write_reg;
  logic [2:0]      memory_bus;
  logic [1:0]      writeBack_bus;
  logic [AWW-1:0]  debug_addr;
  logic            out_pc_src;
  logic [LEN-1:0]  out_pc_branch;
  logic [LEN-1:0]  out_read_data;
  logic [LEN-1:0]  out_alu;
  logic [NBW-1:0]  out_write_reg;
  logic [1:0]      writeBack_bus_out;
  logic [LEN-1:0]  out_debug_data;
  logic            misalign_error;

  int compareCount  = 0;
  int mismatchCount = 0;

  memory_stage #(.len(LEN), .ram_depth(DEPTH)) dut (
    .clk               (clk),
    .reset             (reset),
    .enable            (enable),
    .in_pc_branch      (in_pc_branch),
    .in_alu            (in_alu),
    .in_zero_flag      (in_zero_flag),
    .in_neg_flag       (in_neg_flag),
    .in_reg2           (in_reg2),
    .in_write_reg      (in_write_reg),
    .memory_bus        (memory_bus),
    .writeBack_bus     (writeBack_bus),
    .debug_addr        (debug_addr),
    .out_pc_src        (out_pc_src),
    .out_pc_branch     (out_pc_branch),
    .out_read_data     (out_read_data),
    .out_alu           (out_alu),
    .out_write_reg     (out_write_reg),
    .writeBack_bus_out (writeBack_bus_out),
    .out_debug_data    (out_debug_data),
    .misalign_error    (misalign_error)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expectation and count the result.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    compareCount++;
    if (actual !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Drive one cycle of inputs, clock it in, and settle 1 ns past the edge.
  task automatic applyStimulus(input logic en, input logic [31:0] alu,
                               input logic [31:0] reg2, input logic [2:0] mbus,
                               input logic [1:0] wbus, input logic [NBW-1:0] wreg,
                               input logic [AWW-1:0] dbg);
    enable        = en;
    in_alu        = alu;
    in_reg2       = reg2;
    memory_bus    = mbus;
    writeBack_bus = wbus;
    in_write_reg  = wreg;
    debug_addr    = dbg;
    @(posedge clk);
    #1;
  endtask

  // Directed scenario sequence.
  initial begin
    reset        = 1'b1;
    in_pc_branch = '0;
    in_zero_flag = 1'b0;
    in_neg_flag  = 1'b0;

    // Reset state
    applyStimulus(1'b1, 32'h0, 32'h0, 3'b000, 2'b00, 5'd0, 8'd0);
    checkOutput("rst_read_data", out_read_data, 32'h0);
    checkOutput("rst_alu", out_alu, 32'h0);
    checkOutput("rst_write_reg", 32'(out_write_reg), 32'h0);
    checkOutput("rst_wb_bus", 32'(writeBack_bus_out), 32'h0);
    checkOutput("rst_debug", out_debug_data, 32'h0);
    checkOutput("rst_misalign", 32'(misalign_error), 32'h0);
    reset = 1'b0;

    // Store 0xDEADBEEF at 0x10 (word 4)
    applyStimulus(1'b1, 32'h10, 32'hDEADBEEF, 3'b001, 2'b00, 5'd5, 8'd0);
    checkOutput("st_alu", out_alu, 32'h10);
    checkOutput("st_write_reg", 32'(out_write_reg), 32'd5);
    checkOutput("st_read_data", out_read_data, 32'h0);

    // Load 0x10, debug port also watching word 4
    applyStimulus(1'b1, 32'h10, 32'h0, 3'b010, 2'b11, 5'd7, 8'd4);
    checkOutput("ld_read_data", out_read_data, 32'hDEADBEEF);
    checkOutput("ld_wb_bus", 32'(writeBack_bus_out), 32'h3);
    checkOutput("ld_write_reg", 32'(out_write_reg), 32'd7);
    checkOutput("ld_debug", out_debug_data, 32'hDEADBEEF);
    checkOutput("ld_misalign", 32'(misalign_error), 32'h0);

    // Branch decision is combinational and ignores enable
    memory_bus   = 3'b100;
    in_zero_flag = 1'b1;
    in_pc_branch = 32'h0000_1000;
    enable       = 1'b0;
    #1;
    checkOutput("br_taken", 32'(out_pc_src), 32'h1);
    checkOutput("br_target", out_pc_branch, 32'h0000_1000);
    in_zero_flag = 1'b0;
    #1;
    checkOutput("br_not_taken", 32'(out_pc_src), 32'h0);
    memory_bus   = 3'b000;
    in_zero_flag = 1'b1;
    #1;
    checkOutput("br_no_branch", 32'(out_pc_src), 32'h0);
    in_zero_flag = 1'b0;

    // Preload 0x77 at 0x30 and 0xA at 0x20
    applyStimulus(1'b1, 32'h30, 32'h77, 3'b001, 2'b00, 5'd0, 8'd0);
    applyStimulus(1'b1, 32'h20, 32'hA, 3'b001, 2'b00, 5'd0, 8'd0);

    // Read-first: read and write 0x20 together
    applyStimulus(1'b1, 32'h20, 32'hB, 3'b011, 2'b00, 5'd3, 8'd0);
    checkOutput("rf_old_data", out_read_data, 32'hA);
    applyStimulus(1'b1, 32'h20, 32'h0, 3'b010, 2'b10, 5'd3, 8'd8);
    checkOutput("rf_new_data", out_read_data, 32'hB);

    // Stall for three cycles with a pending store of 0x55 to 0x30
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 32'h30, 32'h55, 3'b001, 2'b01, 5'd9, 8'd12);
      checkOutput($sformatf("stall%0d_alu", i), out_alu, 32'h20);
      checkOutput($sformatf("stall%0d_read_data", i), out_read_data, 32'hB);
      checkOutput($sformatf("stall%0d_wb_bus", i), 32'(writeBack_bus_out), 32'h2);
      checkOutput($sformatf("stall%0d_debug", i), out_debug_data, 32'h77);
    end
    applyStimulus(1'b1, 32'h30, 32'h55, 3'b001, 2'b01, 5'd9, 8'd12);
    checkOutput("resume_alu", out_alu, 32'h30);
    checkOutput("resume_write_reg", 32'(out_write_reg), 32'd9);
    checkOutput("resume_debug_old", out_debug_data, 32'h77);
    applyStimulus(1'b1, 32'h0, 32'h0, 3'b000, 2'b00, 5'd0, 8'd12);
    checkOutput("resume_debug_new", out_debug_data, 32'h55);

    // Misaligned read+write at 0x12 after an aligned load of word 4
    applyStimulus(1'b1, 32'h10, 32'h0, 3'b010, 2'b11, 5'd1, 8'd4);
    checkOutput("pre_mis_read", out_read_data, 32'hDEADBEEF);
    applyStimulus(1'b1, 32'h12, 32'h99, 3'b011, 2'b11, 5'd1, 8'd4);
    checkOutput("mis_read_zero", out_read_data, 32'h0);
    checkOutput("mis_flag", 32'(misalign_error), 32'h1);
    applyStimulus(1'b1, 32'h0, 32'h0, 3'b000, 2'b00, 5'd0, 8'd4);
    checkOutput("mis_mem_unchanged", out_debug_data, 32'hDEADBEEF);
    checkOutput("mis_flag_sticky", 32'(misalign_error), 32'h1);

    // Address wrap: 0x400 maps to word 0
    applyStimulus(1'b1, 32'h400, 32'h1234, 3'b001, 2'b00, 5'd0, 8'd0);
    applyStimulus(1'b1, 32'h0, 32'h0, 3'b000, 2'b00, 5'd0, 8'd0);
    checkOutput("wrap_debug", out_debug_data, 32'h1234);
    checkOutput("wrap_flag_held", 32'(misalign_error), 32'h1);

    // Reset with a coincident store to word 0 that must be dropped
    reset = 1'b1;
    applyStimulus(1'b1, 32'h0, 32'hFFFF, 3'b011, 2'b11, 5'd6, 8'd0);
    checkOutput("rst2_alu", out_alu, 32'h0);
    checkOutput("rst2_read_data", out_read_data, 32'h0);
    checkOutput("rst2_wb_bus", 32'(writeBack_bus_out), 32'h0);
    checkOutput("rst2_debug", out_debug_data, 32'h0);
    checkOutput("rst2_misalign", 32'(misalign_error), 32'h0);
    reset = 1'b0;
    applyStimulus(1'b1, 32'h0, 32'h0, 3'b000, 2'b00, 5'd0, 8'd0);
    checkOutput("rst2_mem_kept", out_debug_data, 32'h1234);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule

// File: doc/memory_stage.md
MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 The block SHALL have parameter len, default 32, meaning datapath width in bits.
REQ-002 The block SHALL have parameter NB, default $clog2(len), meaning register-index width.
REQ-003 The block SHALL have parameter ram_depth, default 256, meaning data memory depth in words; AW = $clog2(ram_depth).
REQ-004 The block SHALL have one clock and a synchronous active-high reset, with these ports:
 clk  input  1  rising-edge clock
 reset  input  1  synchronous, active-high reset
 enable  input  1  pipeline advance; low = stall/hold
 in_pc_branch  input  len  branch target from execute stage
 in_alu  input  len  ALU result; byte address for loads/stores
 in_zero_flag  input  1  ALU zero flag
 in_neg_flag  input  1  ALU negative flag (forwarded only)
 in_reg2  input  len  store data
 in_write_reg  input  NB  destination register index
 memory_bus  input  3  [2] branch, [1] mem_read, [0] mem_write
 writeBack_bus  input  2  [1] reg_write, [0] mem_to_reg
 debug_addr  input  AW  debug word address
 out_pc_src  output  1  branch taken (combinational)
 out_pc_branch  output  len  branch target (combinational pass-through)
 out_read_data  output  len  registered load data
 out_alu  output  len  registered ALU result
 out_write_reg  output  NB  registered destination index
 writeBack_bus_out  output  2  registered write-back controls
 out_debug_data  output  len  registered debug read data
 misalign_error  output  1  sticky misaligned-access flag

Function
REQ-005 out_pc_src SHALL equal memory_bus[2] AND in_zero_flag, combinationally, independent of enable.
REQ-006 out_pc_branch SHALL equal in_pc_branch combinationally.
REQ-007 Data memory SHALL be ram_depth x len, word-addressed by in_alu[AW+1:2]; upper address bits are ignored (addresses wrap modulo ram_depth words).
REQ-008 An access is aligned iff in_alu[1:0] == 2'b00.
REQ-009 On a rising edge with enable=1, reset=0, mem_write=1 and aligned, word[in_alu[AW+1:2]] SHALL be written with in_reg2.
REQ-010 On a rising edge with enable=1, reset=0, out_read_data SHALL load the addressed word's pre-edge contents if mem_read=1 and aligned, else 0; load latency is one cycle.
REQ-011 mem_read and mem_write both set: write SHALL occur and out_read_data SHALL return the old (pre-write) contents (read-first).
REQ-012 On a rising edge with enable=1, reset=0: out_alu <= in_alu, out_write_reg <= in_write_reg, writeBack_bus_out <= writeBack_bus.
REQ-013 With enable=0, all registered outputs except out_debug_data and misalign_error SHALL hold, and no memory write SHALL occur.
REQ-014 Misaligned access (mem_read or mem_write set, in_alu[1:0] != 0, enable=1) SHALL suppress the write, load 0 into out_read_data, and set misalign_error, which SHALL remain set until reset.
REQ-015 out_debug_data SHALL load word[debug_addr] every rising edge regardless of enable (one-cycle latency, read-first versus a same-edge write).

Reset
REQ-016 On a rising edge with reset=1: out_read_data, out_alu, out_debug_data, out_write_reg, writeBack_bus_out and misalign_error SHALL clear to 0; reset SHALL override enable.
REQ-017 Reset SHALL NOT clear data memory contents; a write coincident with reset SHALL be suppressed.

Verification
REQ-018 Store/load: store 0xDEADBEEF at in_alu=0x10, next cycle load 0x10 -> out_read_data=0xDEADBEEF one cycle after load; misalign_error=0.
REQ-019 Branch: memory_bus=3'b100 with in_zero_flag=1 -> out_pc_src=1, out_pc_branch=in_pc_branch same cycle; in_zero_flag=0 -> out_pc_src=0.
REQ-020 Misalign: store at in_alu=0x12 -> memory unchanged (debug read of word 4 shows old value), out_read_data=0, misalign_error=1 and held until reset.
REQ-021 Stall: enable=0 for 3 cycles with mem_write=1 -> no write, registered outputs hold; enable=1 -> write performed.
REQ-022 Wrap/reset: store 0x1234 at in_alu=0x400 (ram_depth=256) -> debug_addr=0 returns 0x1234; assert reset one cycle -> outputs 0, debug_addr=0 still returns 0x1234.
REQ-023 Read-first: mem_read=mem_write=1 at 0x20 holding 0xA, in_reg2=0xB -> out_read_data=0xA, then load 0x20 -> 0xB.
